arb_req_agent: RTL and testbench
================================

Name: arb_req_agent

Overview:
Requester-side front end for the 4-way round-robin arbiter. It buffers commands from 4 source channels in per-channel FIFOs and drives req[3:0] toward the arbiter. It consumes the arbiter's one-cycle one-hot gnt pulses and, for each grant, forwards the head command of the granted channel onto a single shared output with its channel id. It also flags protocol violations and starved channels.

Parameters:
DW, 8, command data width per channel
DEPTH, 2, per-channel FIFO depth (>=1)
TIMEOUT, 15, cycles of unanswered req before starve flag asserts (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset
in_valid  in  4  per-channel command valid
in_data  in  4*DW  channel i data at [i*DW +: DW]
in_ready  out  4  per-channel accept
req  out  4  request to arbiter
gnt  in  4  grant from arbiter; one-cycle one-hot pulse
out_valid  out  1  one-cycle pulse; granted command present
out_id  out  2  channel index of the forwarded command
out_data  out  DW  forwarded command data
err_gnt  out  1  sticky grant-protocol error
starve  out  4  channel i has waited TIMEOUT cycles without a grant

Behaviour:
- Reset: rstn is asynchronous, active-low; clk is the clock. On reset all FIFOs are emptied, all counters are cleared, and out_valid, out_id, out_data, err_gnt and starve are 0. As a result, in_ready=4'b1111 and req=0.
- Reset mid-operation discards all buffered commands. No output pulse is generated for a grant that arrives during reset.
- FIFO i: DEPTH entries with a count register 0..DEPTH.
  - in_ready[i] = (count[i] < DEPTH), decoded from registers only. It has no combinational path from gnt.
  - A push occurs when in_valid[i] & in_ready[i].
- req[i] = (count[i] != 0), decoded from registers. req stays asserted while entries remain; the arbiter's own spacing of grants is tolerated.
- Valid grant: gnt is exactly one-hot, bit i, and count[i] != 0.
  - The head of FIFO i is popped on that edge.
  - On the next cycle out_valid=1, out_id=i, out_data=popped head. Latency from gnt to out_valid is 1 clk.
  - out_valid is 1 for exactly one cycle per valid grant. out_id and out_data hold their last values otherwise (0 after reset).
- Simultaneous push and pop on the same channel: both take effect and count is unchanged. Data order is preserved (FIFO ordering).
- A pop that empties a FIFO drops req[i] on the following cycle.
- gnt=4'b0000: no action.
- Invalid grant (more than one bit set, or a one-hot bit on a channel with count=0):
  - no pop, no out_valid;
  - err_gnt is set the next cycle and stays 1 until reset.
- Starvation counter per channel, width clog2(TIMEOUT+1):
  - cleared when count[i]=0 or when channel i gets a valid grant;
  - otherwise increments each cycle req[i]=1, saturating at TIMEOUT.
  - starve[i] = (counter[i] == TIMEOUT). It is not sticky: it clears with the counter.
- No backpressure on the output: the downstream consumer must accept out_valid every cycle it is asserted.

Test Plan:
- Reset then push 0xA1 on ch2 -> req=4'b0100 next cycle; gnt=4'b0100 pulse -> next cycle out_valid=1, out_id=2, out_data=0xA1; req=0 the cycle after.
- Fill ch0 with 0x11, 0x22 (DEPTH=2) -> in_ready[0]=0. Grant ch0 twice -> outputs 0x11 then 0x22 in order, and in_ready[0]=1 after the first pop.
- With ch1 count=1, push 0x33 and receive gnt=4'b0010 in the same cycle -> count stays 1, out_data=previous head, next grant yields 0x33.
- gnt=4'b0011, or gnt=4'b1000 with ch3 empty -> no out_valid, FIFOs unchanged, err_gnt=1 next cycle and held until rstn is asserted.
- ch0 holds an entry with no grant for 15 cycles (TIMEOUT=15) -> starve[0]=1 on cycle 15; grant ch0 -> starve[0]=0 the next cycle.
- Assert rstn low asynchronously with all FIFOs non-empty -> req, out_valid, err_gnt and starve go 0 immediately, and in_ready=4'b1111.

Source files
------------

// File: rtl/arb_req_agent.sv
// Requester-side front end for a 4-way round-robin arbiter.
// Buffers commands per channel, raises req while a channel has entries,
// forwards the granted channel's head command one cycle after each grant,
// and flags bad grants and starved channels.
module arb_req_agent #(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      req,
  input  logic [3:0]      gnt,
  output logic            out_valid,
  output logic [1:0]      out_id,
  output logic [DW-1:0]   out_data,
  output logic            err_gnt,
  output logic [3:0]      starve
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [NW-1:0] DEPTH_C   = NW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  logic [DW-1:0] mem_q [4][DEPTH];
  logic [NW-1:0] cnt_q [4];
  logic [NW-1:0] cnt_d [4];
  logic [PW-1:0] wr_ptr_q [4];
  logic [PW-1:0] wr_ptr_d [4];
  logic [PW-1:0] rd_ptr_q [4];
  logic [PW-1:0] rd_ptr_d [4];
  logic [CW-1:0] stv_q [4];
  logic [CW-1:0] stv_d [4];

  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_id_q, out_id_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          err_q, err_d;

  logic          gnt_onehot;
  logic [1:0]    gnt_idx;
  logic          gnt_ok;
  logic          gnt_bad;
  logic [3:0]    push;
  logic [3:0]    pop;

  // Flow-control outputs and flags, decoded from registers only.
  always_comb begin
    in_ready = '0;
    req      = '0;
    starve   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_ready[i] = (cnt_q[i] < DEPTH_C);
      req[i]      = (cnt_q[i] != '0);
      starve[i]   = (stv_q[i] == TIMEOUT_C);
    end
  end

  // Grant qualification: exactly one bit set and the granted FIFO non-empty.
  always_comb begin
    gnt_onehot = (gnt != '0) && ((gnt & (gnt - 4'd1)) == '0);
    gnt_idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (gnt[i]) gnt_idx = 2'(i);
    end
    gnt_ok  = gnt_onehot && (cnt_q[gnt_idx] != '0);
    gnt_bad = (gnt != '0) && !gnt_ok;
  end

  // Per-channel FIFO pointer/count and starvation counter next state.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = gnt_ok && (gnt_idx == 2'(i));
      cnt_d[i]    = cnt_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      stv_d[i]    = stv_q[i];
      if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + NW'(1);
      if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - NW'(1);
      if (push[i]) wr_ptr_d[i] = (wr_ptr_q[i] == LAST_PTR) ? '0 : wr_ptr_q[i] + PW'(1);
      if (pop[i])  rd_ptr_d[i] = (rd_ptr_q[i] == LAST_PTR) ? '0 : rd_ptr_q[i] + PW'(1);
      if ((cnt_q[i] == '0) || pop[i]) stv_d[i] = '0;
      else if (stv_q[i] != TIMEOUT_C) stv_d[i] = stv_q[i] + CW'(1);
    end
  end

  // Output pulse, held id/data, and sticky grant error.
  always_comb begin
    out_valid_d = gnt_ok;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    err_d       = err_q || gnt_bad;
    if (gnt_ok) begin
      out_id_d   = gnt_idx;
      out_data_d = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
    end
  end

  // State registers; async reset empties every FIFO and clears all flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q       <= '{default: '0};
      cnt_q       <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      stv_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DW +: DW];
        cnt_q[i]    <= cnt_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        stv_q[i]    <= stv_d[i];
      end
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign err_gnt   = err_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent (DW=8, DEPTH=2, TIMEOUT=15).
module tb_arb_req_agent;

  logic        clk;
  logic        rstn;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [7:0]  out_data;
  logic        err_gnt;
  logic [3:0]  starve;

  int unsigned n_pass;
  int unsigned n_total;

  arb_req_agent #(.DW(8), .DEPTH(2), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .req      (req),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_id   (out_id),
    .out_data (out_data),
    .err_gnt  (err_gnt),
    .starve   (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] din;
    logic [3:0]  g;
    logic [3:0]  rdy;
    logic [3:0]  rq;
    logic        ov;
    logic [1:0]  oid;
    logic [7:0]  od;
    logic        err;
    logic [3:0]  stv;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] rdy, input logic [3:0] rq,
                         input logic ov, input logic [1:0] oid, input logic [7:0] od,
                         input logic err, input logic [3:0] stv);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
    chk({tag, ".req"},       32'(req),       32'(rq));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_id"},    32'(out_id),    32'(oid));
    chk({tag, ".out_data"},  32'(out_data),  32'(od));
    chk({tag, ".err_gnt"},   32'(err_gnt),   32'(err));
    chk({tag, ".starve"},    32'(starve),    32'(stv));
  endtask

  // Apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] iv, input logic [31:0] din, input logic [3:0] g);
    in_valid = iv;
    in_data  = din;
    gnt      = g;
    @(posedge clk);
    #1;
    in_valid = '0;
    in_data  = '0;
    gnt      = '0;
  endtask

  task automatic do_reset();
    in_valid = '0;
    in_data  = '0;
    gnt      = '0;
    rstn     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;

    //         iv       din            gnt      rdy      req      ov oid   od     err stv
    tbl[0]  = '{4'b0100, 32'h00A1_0000, 4'b0000, 4'b1111, 4'b0100, 0, 2'd0, 8'h00, 0, 4'b0000};
    tbl[1]  = '{4'b0000, 32'h0000_0000, 4'b0100, 4'b1111, 4'b0000, 1, 2'd2, 8'hA1, 0, 4'b0000};
    tbl[2]  = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b1111, 4'b0000, 0, 2'd2, 8'hA1, 0, 4'b0000};
    tbl[3]  = '{4'b0001, 32'h0000_0011, 4'b0000, 4'b1111, 4'b0001, 0, 2'd2, 8'hA1, 0, 4'b0000};
    tbl[4]  = '{4'b0001, 32'h0000_0022, 4'b0000, 4'b1110, 4'b0001, 0, 2'd2, 8'hA1, 0, 4'b0000};
    tbl[5]  = '{4'b0001, 32'h0000_0099, 4'b0001, 4'b1111, 4'b0001, 1, 2'd0, 8'h11, 0, 4'b0000};
    tbl[6]  = '{4'b0000, 32'h0000_0000, 4'b0001, 4'b1111, 4'b0000, 1, 2'd0, 8'h22, 0, 4'b0000};
    tbl[7]  = '{4'b0010, 32'h0000_4400, 4'b0000, 4'b1111, 4'b0010, 0, 2'd0, 8'h22, 0, 4'b0000};
    tbl[8]  = '{4'b0010, 32'h0000_3300, 4'b0010, 4'b1111, 4'b0010, 1, 2'd1, 8'h44, 0, 4'b0000};
    tbl[9]  = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b1111, 4'b0000, 1, 2'd1, 8'h33, 0, 4'b0000};
    tbl[10] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b1111, 4'b0000, 0, 2'd1, 8'h33, 0, 4'b0000};
    tbl[11] = '{4'b1000, 32'h5500_0000, 4'b0000, 4'b1111, 4'b1000, 0, 2'd1, 8'h33, 0, 4'b0000};
    tbl[12] = '{4'b0000, 32'h0000_0000, 4'b1001, 4'b1111, 4'b1000, 0, 2'd1, 8'h33, 1, 4'b0000};
    tbl[13] = '{4'b0000, 32'h0000_0000, 4'b1000, 4'b1111, 4'b0000, 1, 2'd3, 8'h55, 1, 4'b0000};

    do_reset();
    chk_all("reset", 4'b1111, 4'b0000, 0, 2'd0, 8'h00, 0, 4'b0000);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].iv, tbl[i].din, tbl[i].g);
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].rq, tbl[i].ov, tbl[i].oid,
              tbl[i].od, tbl[i].err, tbl[i].stv);
    end

    // Multi-bit grant with both granted channels non-empty: no pop, sticky error.
    do_reset();
    step(4'b0011, 32'h0000_2010, 4'b0000);
    chk_all("multi.fill", 4'b1111, 4'b0011, 0, 2'd0, 8'h00, 0, 4'b0000);
    step(4'b0000, 32'h0, 4'b0011);
    chk_all("multi.gnt", 4'b1111, 4'b0011, 0, 2'd0, 8'h00, 1, 4'b0000);
    step(4'b0000, 32'h0, 4'b0000);
    chk("multi.hold.err", 32'(err_gnt), 32'd1);
    step(4'b0000, 32'h0, 4'b0001);
    chk_all("multi.pop0", 4'b1111, 4'b0010, 1, 2'd0, 8'h10, 1, 4'b0000);
    step(4'b0000, 32'h0, 4'b0010);
    chk_all("multi.pop1", 4'b1111, 4'b0000, 1, 2'd1, 8'h20, 1, 4'b0000);

    // One-hot grant to an empty channel.
    do_reset();
    step(4'b0000, 32'h0, 4'b1000);
    chk_all("empty.gnt", 4'b1111, 4'b0000, 0, 2'd0, 8'h00, 1, 4'b0000);
    repeat (3) step(4'b0000, 32'h0, 4'b0000);
    chk("empty.hold.err", 32'(err_gnt), 32'd1);
    do_reset();
    chk("empty.reset.err", 32'(err_gnt), 32'd0);

    // Starvation: counter reaches TIMEOUT 15 cycles after the entry lands.
    do_reset();
    step(4'b0001, 32'h0000_005A, 4'b0000);
    chk("stv.start", 32'(starve), 32'd0);
    repeat (14) step(4'b0000, 32'h0, 4'b0000);
    chk("stv.at14", 32'(starve), 32'd0);
    step(4'b0000, 32'h0, 4'b0000);
    chk("stv.at15", 32'(starve), 32'b0001);
    step(4'b0000, 32'h0, 4'b0000);
    chk("stv.sat", 32'(starve), 32'b0001);
    step(4'b0000, 32'h0, 4'b0001);
    chk_all("stv.gnt", 4'b1111, 4'b0000, 1, 2'd0, 8'h5A, 0, 4'b0000);

    // Asynchronous reset mid-cycle with every FIFO non-empty.
    do_reset();
    step(4'b1111, 32'h4433_2211, 4'b0000);
    step(4'b1111, 32'h8877_6655, 4'b0000);
    chk("ar.full.ready", 32'(in_ready), 32'd0);
    step(4'b0000, 32'h0, 4'b0110);
    step(4'b0000, 32'h0, 4'b0001);
    chk_all("ar.pre", 4'b0001, 4'b1111, 1, 2'd0, 8'h11, 1, 4'b0000);
    #2;
    rstn = 1'b0;
    #1;
    chk_all("ar.async", 4'b1111, 4'b0000, 0, 2'd0, 8'h00, 0, 4'b0000);
    gnt = 4'b0001;
    @(posedge clk);
    #1;
    gnt = 4'b0000;
    chk_all("ar.gnt_in_rst", 4'b1111, 4'b0000, 0, 2'd0, 8'h00, 0, 4'b0000);
    rstn = 1'b1;
    step(4'b0000, 32'h0, 4'b0001);
    chk_all("ar.after", 4'b1111, 4'b0000, 0, 2'd0, 8'h00, 1, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
